ip_packet_rx_buffered: RTL and testbench
========================================

Name: ip_packet_rx_buffered

Overview:
Successor Ethernet/IPv4 receive parser for the accelerator. It consumes the byte-wide AXI-Stream from the MAC and filters frames by EtherType, IP version/IHL, destination IP and, optionally, destination MAC. Accepted payloads are stored in a ring of NUM_BUFFERS frame slots, so the MAC is never back-pressured while the accelerator holds a frame. The block presents frames through a valid/ack handshake and keeps saturating statistics counters.

Parameters:
USER_DATA_BYTES, 785, exact payload length accepted (784 inference + 1 metadata)
NUM_BUFFERS, 2, frame slots in ring (1..4)
CHECK_MAC, 0, 1 = also require dst MAC == ACCELERATOR_MAC_ADDRESS or FF:FF:FF:FF:FF:FF
ETHERTYPE, 16'h0800, required EtherType (byte 12 = [15:8], byte 13 = [7:0])
CNT_WIDTH, 16, statistics counter width

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, synchronous, active-high
ACCELERATOR_IP_ADDRESS  in  32  own IP, first wire byte in [7:0]
ACCELERATOR_MAC_ADDRESS  in  48  own MAC, first wire byte in [7:0]
MAC_DATA_OUT  in  8  stream byte
MAC_DATA_VALID  in  1  byte valid
MAC_DATA_LAST  in  1  last byte of frame
MAC_DATA_TUSER  in  1  1 = bad FCS / MAC error, sampled with LAST
MAC_DATA_READY  out  1  stream ready
DATA_FRAME  out  USER_DATA_BYTES*8  head slot payload, payload byte i at [8i+7:8i]
SRC_IP_ADDRESS  out  32  head slot source IP
SRC_MAC_ADDRESS  out  48  head slot source MAC
FRAME_VALID  out  1  head slot holds a frame
FRAME_ACK  in  1  consumer releases head slot (ignored when FRAME_VALID=0)
RX_OK_COUNT  out  CNT_WIDTH  frames committed
DROP_FILTER_COUNT  out  CNT_WIDTH  frames failing EtherType/version/IP/MAC filter
DROP_ERROR_COUNT  out  CNT_WIDTH  frames with TUSER=1, short, or long
DROP_OVERFLOW_COUNT  out  CNT_WIDTH  good frames dropped because the ring was full

Behaviour:
- Reset state: all outputs 0, MAC_DATA_READY=0, FSM=GET_ETH_HDR, ring empty, counters 0. Slot data is not cleared.
- MAC_DATA_READY=1 in every state except reset. A byte is accepted on VALID&READY.
- FSM states: GET_ETH_HDR (14 B), GET_IP_HDR (20 B), GET_USER_DATA, WAIT_FOR_END.
- Header bytes go into staging registers indexed by byte counter. Field offsets: dst MAC eth[0:5], src MAC eth[6:11], EtherType eth[12:13], ver/IHL ip[0]=8'h45, src IP ip[12:15], dst IP ip[16:19].
- LAST accepted in either header state: DROP_ERROR++, return to GET_ETH_HDR.
- On header byte 19: evaluate the filter and slot availability from registered fields plus the current byte.
  - Filter fail -> WAIT_FOR_END, DROP_FILTER++.
  - Filter pass with occupancy==NUM_BUFFERS -> WAIT_FOR_END, DROP_OVERFLOW++.
  - Otherwise -> GET_USER_DATA and latch src IP/MAC into the write slot.
- GET_USER_DATA writes bytes straight into the write slot.
  - Byte USER_DATA_BYTES-1 with LAST&!TUSER: commit (write ptr +1, occupancy +1), RX_OK++.
  - Same byte with LAST&TUSER: DROP_ERROR++, no commit.
  - LAST earlier than that byte: DROP_ERROR++.
  - Byte USER_DATA_BYTES-1 without LAST: DROP_ERROR++, go to WAIT_FOR_END. If LAST arrives on the very next byte, go straight to GET_ETH_HDR.
  - All outcomes except the too-long case return to GET_ETH_HDR.
- WAIT_FOR_END discards bytes until LAST, then returns to GET_ETH_HDR. Counters are not incremented again.
- Latency: FRAME_VALID rises on the cycle after the committing byte when the ring was empty.
- FRAME_VALID=(occupancy!=0). DATA_FRAME and SRC_* come from the read slot and are stable while FRAME_VALID=1.
- FRAME_VALID&FRAME_ACK: read ptr +1, occupancy -1. If the next slot is full, FRAME_VALID stays 1 with the new data on the next cycle.
- Commit and ack in the same cycle: occupancy unchanged, both pointers advance.
- The overflow decision is made only at IP byte 19. An ack during the dropped payload does not rescue that frame.
- Pointers wrap modulo NUM_BUFFERS.
- Statistics counters saturate at all-ones.
- ARESET mid-frame: the remainder of that frame is parsed as a new frame. It fails checks and is counted in DROP_FILTER or DROP_ERROR. No stale commit occurs.

Decomposition:
- Package ip_rx_pkg holds: state enum, header offset/size constants (ETH_HDR_SIZE_BYTES=14, IP_HDR_SIZE_BYTES=20, field offsets), IPV4_VER_IHL=8'h45, BROADCAST_MAC.
- The byte counter reuses counter_sync_reset.
- New sub-module sat_counter (parameter WIDTH; ports clk, sync reset, inc; saturating), instantiated 4 times.
- Slot storage is an array of USER_DATA_BYTES*8 registers inside the top module.

Test Plan:
1. Good frame: EtherType 0800, 45, dst IP = own, 785 payload bytes i%256, TUSER=0 -> FRAME_VALID next cycle, DATA_FRAME byte i = i%256, SRC_IP/MAC match, RX_OK=1.
2. Three good frames back-to-back with no ack, NUM_BUFFERS=2 -> first two held, third counted DROP_OVERFLOW=1. Ack twice -> second frame presented, then FRAME_VALID=0.
3. Wrong dst IP, then EtherType 0x86DD -> DROP_FILTER=2, no FRAME_VALID. CHECK_MAC=1 with broadcast dst MAC and own IP -> accepted.
4. Payload 784 bytes with LAST, then 786 bytes, then 785 with TUSER=1 -> DROP_ERROR=3, FSM back to GET_ETH_HDR each time, a following good frame is accepted.
5. LAST at eth byte 5 -> DROP_ERROR++. The next frame parses correctly.
6. Commit coinciding with FRAME_ACK at occupancy 1 -> occupancy stays 1, new frame presented next cycle. ARESET mid-payload -> all counters 0, FRAME_VALID=0.

Source files
------------

// File: rtl/ip_rx_pkg.sv
// Shared types and header layout constants for the Ethernet/IPv4 receive parser.
package ip_rx_pkg;

    typedef enum logic [1:0] {
        GET_ETH_HDR   = 2'd0,
        GET_IP_HDR    = 2'd1,
        GET_USER_DATA = 2'd2,
        WAIT_FOR_END  = 2'd3
    } rx_state_t;

    localparam int ETH_HDR_SIZE_BYTES = 14;
    localparam int IP_HDR_SIZE_BYTES  = 20;

    localparam int ETH_DST_MAC_OFS = 0;
    localparam int ETH_SRC_MAC_OFS = 6;
    localparam int ETH_TYPE_OFS    = 12;
    localparam int IP_VER_IHL_OFS  = 0;
    localparam int IP_SRC_IP_OFS   = 12;
    localparam int IP_DST_IP_OFS   = 16;

    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/counter_sync_reset.sv
// Up-counter with synchronous reset and synchronous clear; clear wins over increment.
module counter_sync_reset #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (srst || clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ip_packet_rx_buffered.sv
// Byte-wide Ethernet/IPv4 receive filter that stores accepted payloads in a ring
// of frame slots and presents the oldest one through a valid/ack handshake.
module ip_packet_rx_buffered
    import ip_rx_pkg::*;
#(
    parameter int          USER_DATA_BYTES = 785,
    parameter int          NUM_BUFFERS     = 2,
    parameter bit          CHECK_MAC       = 1'b0,
    parameter logic [15:0] ETHERTYPE       = 16'h0800,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]                   MAC_DATA_OUT,
    input  logic                         MAC_DATA_VALID,
    input  logic                         MAC_DATA_LAST,
    input  logic                         MAC_DATA_TUSER,
    output logic                         MAC_DATA_READY,
    output logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    output logic [31:0]                  SRC_IP_ADDRESS,
    output logic [47:0]                  SRC_MAC_ADDRESS,
    output logic                         FRAME_VALID,
    input  logic                         FRAME_ACK,
    output logic [CNT_WIDTH-1:0]         RX_OK_COUNT,
    output logic [CNT_WIDTH-1:0]         DROP_FILTER_COUNT,
    output logic [CNT_WIDTH-1:0]         DROP_ERROR_COUNT,
    output logic [CNT_WIDTH-1:0]         DROP_OVERFLOW_COUNT
);

    localparam int FRAME_BITS = USER_DATA_BYTES * 8;
    localparam int BCNT_W     = $clog2((USER_DATA_BYTES > IP_HDR_SIZE_BYTES) ?
                                       USER_DATA_BYTES : IP_HDR_SIZE_BYTES);
    localparam int PTR_W      = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam int OCC_W      = $clog2(NUM_BUFFERS + 1);

    localparam logic [BCNT_W-1:0] ETH_LAST_IDX  = BCNT_W'(ETH_HDR_SIZE_BYTES - 1);
    localparam logic [BCNT_W-1:0] IP_LAST_IDX   = BCNT_W'(IP_HDR_SIZE_BYTES - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST_IDX = BCNT_W'(USER_DATA_BYTES - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX       = PTR_W'(NUM_BUFFERS - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL      = OCC_W'(NUM_BUFFERS);

    rx_state_t state_q, state_d;
    logic      ready_q;
    logic      accept;

    logic [BCNT_W-1:0] byte_cnt;
    logic              byte_cnt_clr;
    logic              byte_cnt_inc;

    logic [7:0]  eth_hdr_q [ETH_HDR_SIZE_BYTES];
    logic [7:0]  ver_ihl_q;
    logic [31:0] hdr_src_ip_q;
    logic [23:0] hdr_dst_ip_q;

    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [31:0] dst_ip;
    logic        mac_ok;
    logic        filter_pass;

    logic commit, latch_src;
    logic inc_ok, inc_filter, inc_error, inc_overflow;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             frame_valid;
    logic             frame_ack;

    logic [FRAME_BITS-1:0] slot_data_q    [NUM_BUFFERS];
    logic [31:0]           slot_src_ip_q  [NUM_BUFFERS];
    logic [47:0]           slot_src_mac_q [NUM_BUFFERS];

    logic [3:0]                 stat_inc;
    logic [3:0][CNT_WIDTH-1:0]  stat_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept = MAC_DATA_VALID && ready_q;

    counter_sync_reset #(
        .WIDTH (BCNT_W)
    ) u_byte_cnt (
        .clk     (ACLK),
        .srst    (ARESET),
        .clr_i   (byte_cnt_clr),
        .inc_i   (byte_cnt_inc),
        .count_o (byte_cnt)
    );

    // Counter restarts at every state change and at every frame end.
    assign byte_cnt_clr = accept && (MAC_DATA_LAST || (state_d != state_q));
    assign byte_cnt_inc = accept && (state_q != WAIT_FOR_END);

    always_ff @(posedge ACLK) begin
        if (accept && (state_q == GET_ETH_HDR)) begin
            for (int i = 0; i < ETH_HDR_SIZE_BYTES; i++) begin
                if (byte_cnt == BCNT_W'(i)) begin
                    eth_hdr_q[i] <= MAC_DATA_OUT;
                end
            end
        end
        if (accept && (state_q == GET_IP_HDR)) begin
            if (byte_cnt == BCNT_W'(IP_VER_IHL_OFS)) begin
                ver_ihl_q <= MAC_DATA_OUT;
            end
            for (int i = 0; i < 4; i++) begin
                if (byte_cnt == BCNT_W'(IP_SRC_IP_OFS + i)) begin
                    hdr_src_ip_q[i*8 +: 8] <= MAC_DATA_OUT;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (byte_cnt == BCNT_W'(IP_DST_IP_OFS + i)) begin
                    hdr_dst_ip_q[i*8 +: 8] <= MAC_DATA_OUT;
                end
            end
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_mac_fields
        assign dst_mac[gi*8 +: 8] = eth_hdr_q[ETH_DST_MAC_OFS + gi];
        assign src_mac[gi*8 +: 8] = eth_hdr_q[ETH_SRC_MAC_OFS + gi];
    end

    // The last dst IP byte is the one on the bus when the filter is evaluated.
    assign dst_ip   = {MAC_DATA_OUT, hdr_dst_ip_q};
    assign eth_type = {eth_hdr_q[ETH_TYPE_OFS], eth_hdr_q[ETH_TYPE_OFS + 1]};
    assign mac_ok   = !CHECK_MAC || (dst_mac == ACCELERATOR_MAC_ADDRESS) ||
                      (dst_mac == BROADCAST_MAC);
    assign filter_pass = (eth_type == ETHERTYPE) && (ver_ihl_q == IPV4_VER_IHL) &&
                         (dst_ip == ACCELERATOR_IP_ADDRESS) && mac_ok;

    always_comb begin
        state_d      = state_q;
        commit       = 1'b0;
        latch_src    = 1'b0;
        inc_ok       = 1'b0;
        inc_filter   = 1'b0;
        inc_error    = 1'b0;
        inc_overflow = 1'b0;
        if (accept) begin
            case (state_q)
                GET_ETH_HDR: begin
                    if (MAC_DATA_LAST) begin
                        inc_error = 1'b1;
                    end else if (byte_cnt == ETH_LAST_IDX) begin
                        state_d = GET_IP_HDR;
                    end
                end
                GET_IP_HDR: begin
                    if (MAC_DATA_LAST) begin
                        inc_error = 1'b1;
                        state_d   = GET_ETH_HDR;
                    end else if (byte_cnt == IP_LAST_IDX) begin
                        if (!filter_pass) begin
                            inc_filter = 1'b1;
                            state_d    = WAIT_FOR_END;
                        end else if (occ_q == OCC_FULL) begin
                            inc_overflow = 1'b1;
                            state_d      = WAIT_FOR_END;
                        end else begin
                            latch_src = 1'b1;
                            state_d   = GET_USER_DATA;
                        end
                    end
                end
                GET_USER_DATA: begin
                    if (MAC_DATA_LAST) begin
                        state_d = GET_ETH_HDR;
                        if ((byte_cnt == DATA_LAST_IDX) && !MAC_DATA_TUSER) begin
                            commit = 1'b1;
                            inc_ok = 1'b1;
                        end else begin
                            inc_error = 1'b1;
                        end
                    end else if (byte_cnt == DATA_LAST_IDX) begin
                        inc_error = 1'b1;
                        state_d   = WAIT_FOR_END;
                    end
                end
                WAIT_FOR_END: begin
                    if (MAC_DATA_LAST) begin
                        state_d = GET_ETH_HDR;
                    end
                end
                default: state_d = GET_ETH_HDR;
            endcase
        end
    end

    // The write slot is never the presented slot while the ring holds a frame.
    always_ff @(posedge ACLK) begin
        if (accept && (state_q == GET_USER_DATA)) begin
            slot_data_q[wr_ptr_q][{byte_cnt, 3'b000} +: 8] <= MAC_DATA_OUT;
        end
        if (latch_src) begin
            slot_src_ip_q[wr_ptr_q]  <= hdr_src_ip_q;
            slot_src_mac_q[wr_ptr_q] <= src_mac;
        end
    end

    assign frame_valid = (occ_q != '0);
    assign frame_ack   = frame_valid && FRAME_ACK;

    always_comb begin
        wr_ptr_d = commit    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = frame_ack ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (commit && !frame_ack) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!commit && frame_ack) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= GET_ETH_HDR;
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign stat_inc = {inc_overflow, inc_error, inc_filter, inc_ok};

    for (genvar gi = 0; gi < 4; gi++) begin : g_stats
        sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_stat (
            .clk     (ACLK),
            .srst    (ARESET),
            .inc_i   (stat_inc[gi]),
            .count_o (stat_cnt[gi])
        );
    end

    assign MAC_DATA_READY      = ready_q;
    assign FRAME_VALID         = frame_valid;
    assign DATA_FRAME          = frame_valid ? slot_data_q[rd_ptr_q]    : '0;
    assign SRC_IP_ADDRESS      = frame_valid ? slot_src_ip_q[rd_ptr_q]  : '0;
    assign SRC_MAC_ADDRESS     = frame_valid ? slot_src_mac_q[rd_ptr_q] : '0;
    assign RX_OK_COUNT         = stat_cnt[0];
    assign DROP_FILTER_COUNT   = stat_cnt[1];
    assign DROP_ERROR_COUNT    = stat_cnt[2];
    assign DROP_OVERFLOW_COUNT = stat_cnt[3];

endmodule

// File: tb/tb_ip_packet_rx_buffered.sv
// Frame-level bench: table of frames with expected outcomes, plus hand-built
// overflow, commit-with-ack and mid-frame reset sequences; payloads via scoreboard.
module tb_ip_packet_rx_buffered;

    localparam int          UDB     = 785;
    localparam int          NB      = 2;
    localparam int          CW      = 3;
    localparam int          CMAX    = (1 << CW) - 1;
    localparam logic [31:0] OWN_IP  = 32'h0201_A8C0;
    localparam logic [47:0] OWN_MAC = 48'h6655_4433_2211;
    localparam logic [47:0] BC_MAC  = 48'hFFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             ARESET;
    logic [31:0]      ACCELERATOR_IP_ADDRESS;
    logic [47:0]      ACCELERATOR_MAC_ADDRESS;
    logic [7:0]       MAC_DATA_OUT;
    logic             MAC_DATA_VALID;
    logic             MAC_DATA_LAST;
    logic             MAC_DATA_TUSER;
    logic             MAC_DATA_READY;
    logic [UDB*8-1:0] DATA_FRAME;
    logic [31:0]      SRC_IP_ADDRESS;
    logic [47:0]      SRC_MAC_ADDRESS;
    logic             FRAME_VALID;
    logic             FRAME_ACK;
    logic [CW-1:0]    RX_OK_COUNT;
    logic [CW-1:0]    DROP_FILTER_COUNT;
    logic [CW-1:0]    DROP_ERROR_COUNT;
    logic [CW-1:0]    DROP_OVERFLOW_COUNT;

    always #5 clk = ~clk;

    ip_packet_rx_buffered #(
        .USER_DATA_BYTES (UDB),
        .NUM_BUFFERS     (NB),
        .CHECK_MAC       (1'b1),
        .ETHERTYPE       (16'h0800),
        .CNT_WIDTH       (CW)
    ) dut (
        .ACLK                    (clk),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
        .MAC_DATA_OUT            (MAC_DATA_OUT),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .DATA_FRAME              (DATA_FRAME),
        .SRC_IP_ADDRESS          (SRC_IP_ADDRESS),
        .SRC_MAC_ADDRESS         (SRC_MAC_ADDRESS),
        .FRAME_VALID             (FRAME_VALID),
        .FRAME_ACK               (FRAME_ACK),
        .RX_OK_COUNT             (RX_OK_COUNT),
        .DROP_FILTER_COUNT       (DROP_FILTER_COUNT),
        .DROP_ERROR_COUNT        (DROP_ERROR_COUNT),
        .DROP_OVERFLOW_COUNT     (DROP_OVERFLOW_COUNT)
    );

    typedef struct {
        string       name;
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] etype;
        logic [7:0]  ver_ihl;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        int          plen;
        logic        tuser;
        int          trunc_at;
        logic [7:0]  seed;
        int          exp_ok;
        int          exp_filt;
        int          exp_err;
        int          exp_ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [7:0]  seed;
        logic [31:0] src_ip;
        logic [47:0] src_mac;
    } sb_t;

    vec_t       vecs[$];
    sb_t        sb_q[$];
    logic [7:0] fb[$];
    logic [UDB*8-1:0] exp_frame;

    int checks   = 0;
    int failures = 0;
    int tot_ok   = 0;
    int tot_filt = 0;
    int tot_err  = 0;
    int tot_ovf  = 0;

    function automatic vec_t mk(input string name, input logic [47:0] dmac,
                                input logic [15:0] et, input logic [7:0] vi,
                                input logic [31:0] dip, input int plen,
                                input logic tuser, input int trunc_at,
                                input logic [7:0] seed, input int ok,
                                input int filt, input int err, input int ovf);
        vec_t v;
        v.name = name;   v.dst_mac = dmac;   v.etype = et;   v.ver_ihl = vi;
        v.dst_ip = dip;  v.plen = plen;      v.tuser = tuser; v.trunc_at = trunc_at;
        v.seed = seed;   v.exp_ok = ok;      v.exp_filt = filt;
        v.exp_err = err; v.exp_ovf = ovf;
        v.src_mac = {40'h02_0000_00AB, seed};
        v.src_ip  = {24'h0A_0B0C, seed};
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(v.dst_mac[i*8 +: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(v.src_mac[i*8 +: 8]);
        fb.push_back(v.etype[15:8]);
        fb.push_back(v.etype[7:0]);
        fb.push_back(v.ver_ihl);
        for (int i = 1; i < 12; i++) fb.push_back(8'h00);
        for (int i = 0; i < 4; i++) fb.push_back(v.src_ip[i*8 +: 8]);
        for (int i = 0; i < 4; i++) fb.push_back(v.dst_ip[i*8 +: 8]);
        for (int i = 0; i < v.plen; i++) fb.push_back(8'(v.seed + i));
        if (v.trunc_at >= 0) begin
            while (fb.size() > v.trunc_at + 1) void'(fb.pop_back());
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic tuser);
        MAC_DATA_OUT   = d;
        MAC_DATA_VALID = 1'b1;
        MAC_DATA_LAST  = last;
        MAC_DATA_TUSER = tuser;
        @(posedge clk);
        #1;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
    endtask

    task automatic drive_range(input int from, input int to, input logic mark_last,
                               input logic tuser);
        for (int i = from; i <= to; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_byte(fb[i], mark_last && (i == to), tuser && mark_last && (i == to));
        end
    endtask

    task automatic check_head(input string tag, input logic do_ack);
        sb_t e;
        int  bad;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_valid"}, 64'(FRAME_VALID), 64'd1);
        for (int i = 0; i < UDB; i++) exp_frame[i*8 +: 8] = 8'(e.seed + i);
        checks++;
        if (DATA_FRAME !== exp_frame) begin
            failures++;
            bad = 0;
            for (int i = UDB - 1; i >= 0; i--) begin
                if (DATA_FRAME[i*8 +: 8] !== exp_frame[i*8 +: 8]) bad = i;
            end
            $display("FAIL %s_data(%s) byte %0d actual=%0h required=%0h", tag, e.name,
                     bad, DATA_FRAME[bad*8 +: 8], exp_frame[bad*8 +: 8]);
        end
        chk({tag, "_src_ip"}, 64'(SRC_IP_ADDRESS), 64'(e.src_ip));
        chk({tag, "_src_mac"}, 64'(SRC_MAC_ADDRESS), 64'(e.src_mac));
        if (do_ack) begin
            FRAME_ACK = 1'b1;
            @(posedge clk);
            #1;
            FRAME_ACK = 1'b0;
        end
    endtask

    task automatic send(input vec_t v, input logic ack_on_last);
        sb_t e;
        build(v);
        if (v.exp_ok != 0) begin
            e.name = v.name; e.seed = v.seed; e.src_ip = v.src_ip; e.src_mac = v.src_mac;
            sb_q.push_back(e);
        end
        if (ack_on_last) begin
            drive_range(0, fb.size() - 2, 1'b0, 1'b0);
            check_head({v.name, "_prev"}, 1'b0);
            FRAME_ACK = 1'b1;
            drive_byte(fb[fb.size() - 1], 1'b1, v.tuser);
            FRAME_ACK = 1'b0;
        end else begin
            drive_range(0, fb.size() - 1, 1'b1, v.tuser);
        end
        tot_ok   += v.exp_ok;
        tot_filt += v.exp_filt;
        tot_err  += v.exp_err;
        tot_ovf  += v.exp_ovf;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_rx_ok"},    64'(RX_OK_COUNT),         64'(sat(tot_ok)));
        chk({tag, "_filter"},   64'(DROP_FILTER_COUNT),   64'(sat(tot_filt)));
        chk({tag, "_error"},    64'(DROP_ERROR_COUNT),    64'(sat(tot_err)));
        chk({tag, "_overflow"}, 64'(DROP_OVERFLOW_COUNT), 64'(sat(tot_ovf)));
    endtask

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vx;
        vec_t vy;
        ACCELERATOR_IP_ADDRESS  = OWN_IP;
        ACCELERATOR_MAC_ADDRESS = OWN_MAC;
        MAC_DATA_OUT   = 8'h00;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        FRAME_ACK      = 1'b0;
        ARESET         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(MAC_DATA_READY), 64'd0);
        chk("reset_valid", 64'(FRAME_VALID), 64'd0);
        chk("reset_data_zero", 64'(DATA_FRAME == '0), 64'd1);
        chk("reset_src_ip", 64'(SRC_IP_ADDRESS), 64'd0);
        check_counters("reset");
        ARESET = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(MAC_DATA_READY), 64'd1);

        //          name             dst mac   etype     ver    dst ip                  plen tu trunc seed ok f  e  o
        vecs.push_back(mk("good_own",     OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, -1,  0,  1, 0, 0, 0));
        vecs.push_back(mk("good_bcast",   BC_MAC,  16'h0800, 8'h45, OWN_IP,                 785, 0, -1,  77, 1, 0, 0, 0));
        vecs.push_back(mk("bad_dst_ip",   OWN_MAC, 16'h0800, 8'h45, OWN_IP ^ 32'h0100_0000, 785, 0, -1,  2,  0, 1, 0, 0));
        vecs.push_back(mk("bad_etype",    OWN_MAC, 16'h86DD, 8'h45, OWN_IP,                 785, 0, -1,  3,  0, 1, 0, 0));
        vecs.push_back(mk("bad_ver_ihl",  OWN_MAC, 16'h0800, 8'h46, OWN_IP,                 785, 0, -1,  4,  0, 1, 0, 0));
        vecs.push_back(mk("bad_dst_mac",  48'h6655_4433_2212, 16'h0800, 8'h45, OWN_IP,      785, 0, -1,  5,  0, 1, 0, 0));
        vecs.push_back(mk("short_784",    OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 784, 0, -1,  6,  0, 0, 1, 0));
        vecs.push_back(mk("long_786",     OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 786, 0, -1,  7,  0, 0, 1, 0));
        vecs.push_back(mk("tuser_err",    OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 1, -1,  8,  0, 0, 1, 0));
        vecs.push_back(mk("last_eth5",    OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, 5,   9,  0, 0, 1, 0));
        vecs.push_back(mk("last_ip19",    OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, 33,  10, 0, 0, 1, 0));
        vecs.push_back(mk("long_900",     OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 900, 0, -1,  11, 0, 0, 1, 0));
        vecs.push_back(mk("last_eth0",    OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, 0,   12, 0, 0, 1, 0));
        vecs.push_back(mk("last_eth13",   OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, 13,  13, 0, 0, 1, 0));
        vecs.push_back(mk("good_after",   OWN_MAC, 16'h0800, 8'h45, OWN_IP,                 785, 0, -1,  14, 1, 0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            send(vecs[k], 1'b0);
            chk({vecs[k].name, "_valid_next"}, 64'(FRAME_VALID), 64'(vecs[k].exp_ok != 0));
            check_counters(vecs[k].name);
            if (vecs[k].exp_ok != 0) check_head(vecs[k].name, 1'b1);
            chk({vecs[k].name, "_valid_after"}, 64'(FRAME_VALID), 64'd0);
        end

        // Ring overflow: two frames held, third dropped at IP byte 19.
        send(mk("ovf_a", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 100, 1, 0, 0, 0), 1'b0);
        send(mk("ovf_b", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 110, 1, 0, 0, 0), 1'b0);
        send(mk("ovf_c", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 120, 0, 0, 0, 1), 1'b0);
        check_counters("ovf");
        check_head("ovf_first", 1'b1);
        chk("ovf_second_valid", 64'(FRAME_VALID), 64'd1);
        check_head("ovf_second", 1'b1);
        chk("ovf_drained", 64'(FRAME_VALID), 64'd0);

        // Commit of a new frame in the same cycle the held frame is acknowledged.
        vx = mk("cack_x", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 130, 1, 0, 0, 0);
        vy = mk("cack_y", BC_MAC,  16'h0800, 8'h45, OWN_IP, 785, 0, -1, 140, 1, 0, 0, 0);
        send(vx, 1'b0);
        chk("cack_x_held", 64'(FRAME_VALID), 64'd1);
        send(vy, 1'b1);
        chk("cack_valid", 64'(FRAME_VALID), 64'd1);
        check_counters("cack");
        check_head("cack_y", 1'b1);
        chk("cack_occ_one", 64'(FRAME_VALID), 64'd0);

        // Reset in the middle of a payload; the tail must be parsed as a new frame.
        vx = mk("rst_mid", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 40, 0, 0, 0, 0);
        build(vx);
        drive_range(0, 133, 1'b0, 1'b0);
        ARESET = 1'b1;
        @(posedge clk);
        #1;
        tot_ok = 0; tot_filt = 0; tot_err = 0; tot_ovf = 0;
        chk("rst_mid_ready", 64'(MAC_DATA_READY), 64'd0);
        chk("rst_mid_valid", 64'(FRAME_VALID), 64'd0);
        check_counters("rst_mid");
        ARESET = 1'b0;
        @(posedge clk);
        #1;
        drive_range(134, fb.size() - 1, 1'b1, 1'b0);
        tot_filt = 1;
        chk("rst_tail_valid", 64'(FRAME_VALID), 64'd0);
        check_counters("rst_tail");
        send(mk("rst_recover", OWN_MAC, 16'h0800, 8'h45, OWN_IP, 785, 0, -1, 150, 1, 0, 0, 0), 1'b0);
        chk("rst_recover_valid", 64'(FRAME_VALID), 64'd1);
        check_counters("rst_recover");
        check_head("rst_recover", 1'b1);
        chk("rst_recover_drained", 64'(FRAME_VALID), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
